sound_cmd_queue: RTL and testbench

SOUND_CMD_QUEUE -- requirements
Module: sound_cmd_queue

---
 rtl/sound_cmd_queue_if.sv | 25 ++
 rtl/sound_cmd_queue.sv | 142 ++++++++++++++
 tb/tb_sound_cmd_queue.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sound_cmd_queue_if.sv
// Bus bundle between the main CPU / sound CPU side and the sound command queue.
// The master modport is the CPU-side driver; the slave modport is the queue itself.
interface sound_cmd_queue_if;
   logic       mcpu_wr;
   logic [7:0] mcpu_din;
   logic       scpu_rd;
   logic       scpu_iack;
   logic       ovf_clr;
   logic [7:0] scpu_dout;
   logic       scpu_int;
   logic [2:0] q_count;
   logic       q_empty;
   logic       q_full;
   logic       overflow;

   modport master (
      output mcpu_wr, mcpu_din, scpu_rd, scpu_iack, ovf_clr,
      input  scpu_dout, scpu_int, q_count, q_empty, q_full, overflow
   );

   modport slave (
      input  mcpu_wr, mcpu_din, scpu_rd, scpu_iack, ovf_clr,
      output scpu_dout, scpu_int, q_count, q_empty, q_full, overflow
   );
endinterface

// File: rtl/sound_cmd_queue.sv
// Main-CPU to sound-CPU command queue with edge-detected strobes and an interrupt FSM.
// Define SOUND_CMD_QUEUE_FIFO_EN for a 4-deep FIFO; otherwise a single overwriting latch.
module sound_cmd_queue (
   input logic               clk_sys,
   input logic               reset,
   sound_cmd_queue_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, PEND, SERVICE} int_state_t;

   int_state_t state;
   logic       int_r;
   logic       wr_q, rd_q, iack_q;
   logic       push, pop, iack_rise;
   logic       q_empty, q_full;
   logic       ovf_event;
   logic       overflow_r;
   logic [2:0] count;
   logic [7:0] head;

   // Strobes are level signals held for a whole bus cycle, so act only on their first edge.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_q   <= 1'b0;
         rd_q   <= 1'b0;
         iack_q <= 1'b0;
      end else begin
         wr_q   <= bus.mcpu_wr;
         rd_q   <= bus.scpu_rd;
         iack_q <= bus.scpu_iack;
      end
   end

   assign push      = bus.mcpu_wr & ~wr_q;
   assign pop       = bus.scpu_rd & ~rd_q & ~q_empty;
   assign iack_rise = bus.scpu_iack & ~iack_q;

`ifdef SOUND_CMD_QUEUE_FIFO_EN
   logic [7:0] mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic       do_write;

   // When full, a simultaneous pop frees the slot the write pointer is aiming at.
   assign do_write  = push & (~q_full | pop);
   assign ovf_event = push & q_full & ~pop;
   assign q_empty   = (count == 3'd0);
   assign q_full    = (count == 3'd4);
   assign head      = mem[rd_ptr];

   always_ff @(posedge clk_sys) begin
      if (do_write) mem[wr_ptr] <= bus.mcpu_din;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + 2'd1;
         if (pop)      rd_ptr <= rd_ptr + 2'd1;
         case ({do_write, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end
`else
   logic [7:0] held;
   logic       held_valid;

   // A push into a full latch replaces the byte; the lost command is flagged as overflow.
   assign ovf_event = push & q_full & ~pop;
   assign q_empty   = ~held_valid;
   assign q_full    = held_valid;
   assign count     = {2'b00, held_valid};
   assign head      = held;

   always_ff @(posedge clk_sys) begin
      if (push) held <= bus.mcpu_din;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         held_valid <= 1'b0;
      end else if (push) begin
         held_valid <= 1'b1;
      end else if (pop) begin
         held_valid <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         overflow_r <= 1'b0;
      end else if (ovf_event) begin
         overflow_r <= 1'b1;
      end else if (bus.ovf_clr) begin
         overflow_r <= 1'b0;
      end
   end

   // The interrupt line is held only while waiting for acknowledge; SERVICE waits for the read.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         int_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!q_empty) begin
                  state <= PEND;
                  int_r <= 1'b1;
               end
            end
            PEND: begin
               if (iack_rise) begin
                  state <= SERVICE;
                  int_r <= 1'b0;
               end
            end
            SERVICE: begin
               if (pop) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               int_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.scpu_dout = q_empty ? 8'hFF : head;
   assign bus.scpu_int  = int_r;
   assign bus.q_count   = count;
   assign bus.q_empty   = q_empty;
   assign bus.q_full    = q_full;
   assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_sound_cmd_queue.sv
// Directed bench for sound_cmd_queue; read data is checked by a scoreboard monitor.
// Expectations follow the build selected by SOUND_CMD_QUEUE_FIFO_EN.
module tb_sound_cmd_queue;

   logic clk_sys;
   logic reset;
   int   compared;
   int   mismatched;
   logic [7:0] exp_q [$];
   logic rd_prev;

   sound_cmd_queue_if bus();

   sound_cmd_queue dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus.slave)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic wr, input logic [7:0] din, input logic rd,
                                input logic iack, input logic clr);
      bus.mcpu_wr   = wr;
      bus.mcpu_din  = din;
      bus.scpu_rd   = rd;
      bus.scpu_iack = iack;
      bus.ovf_clr   = clr;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic pushByte(input logic [7:0] d);
      applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, d, 1'b0, 1'b0, 1'b0);
      tick(1);
   endtask

   task automatic popByte();
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulseIack();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic waitInt(input string name);
      int n;
      n = 0;
      while (bus.scpu_int !== 1'b1 && n < 8) begin
         tick(1);
         n++;
      end
      checkOutput(name, {7'd0, bus.scpu_int}, 8'h01);
   endtask

   task automatic serviceOne(input string name);
      waitInt({name, "_int"});
      pulseIack();
      checkOutput({name, "_int_drop"}, {7'd0, bus.scpu_int}, 8'h00);
      popByte();
   endtask

   // Each rising read strobe is checked against the oldest expected byte (FFh when none).
   always @(negedge clk_sys) begin
      if (reset) begin
         rd_prev <= 1'b0;
      end else begin
         if (bus.scpu_rd === 1'b1 && rd_prev === 1'b0) begin
            if (exp_q.size() > 0) checkOutput("read_data", bus.scpu_dout, exp_q.pop_front());
            else                  checkOutput("read_empty", bus.scpu_dout, 8'hFF);
         end
         rd_prev <= bus.scpu_rd;
      end
   end

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      #2;
      checkOutput("rst_dout", bus.scpu_dout, 8'hFF);
      checkOutput("rst_count", {5'd0, bus.q_count}, 8'h00);
      checkOutput("rst_empty", {7'd0, bus.q_empty}, 8'h01);
      checkOutput("rst_full", {7'd0, bus.q_full}, 8'h00);
      checkOutput("rst_int", {7'd0, bus.scpu_int}, 8'h00);
      tick(2);
      reset = 1'b0;
      tick(1);

      // Long write strobe gives a single push
      applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(8'h42);
      tick(1);
      checkOutput("push_dout", bus.scpu_dout, 8'h42);
      checkOutput("push_int_early", {7'd0, bus.scpu_int}, 8'h00);
      tick(1);
      checkOutput("push_int", {7'd0, bus.scpu_int}, 8'h01);
      tick(3);
      checkOutput("push_once_count", {5'd0, bus.q_count}, 8'h01);
      checkOutput("push_once_ovf", {7'd0, bus.overflow}, 8'h00);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Acknowledge then read
      pulseIack();
      checkOutput("iack_int", {7'd0, bus.scpu_int}, 8'h00);
      popByte();
      checkOutput("pop_dout", bus.scpu_dout, 8'hFF);
      checkOutput("pop_empty", {7'd0, bus.q_empty}, 8'h01);
      tick(1);
      checkOutput("idle_int", {7'd0, bus.scpu_int}, 8'h00);

      // Acknowledge while idle and a read while empty do nothing
      pulseIack();
      tick(1);
      checkOutput("idle_iack_int", {7'd0, bus.scpu_int}, 8'h00);
      popByte();
      checkOutput("empty_pop_count", {5'd0, bus.q_count}, 8'h00);

`ifdef SOUND_CMD_QUEUE_FIFO_EN
      for (int i = 1; i <= 5; i++) pushByte(8'(i));
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h04);
      checkOutput("fifo_full", {7'd0, bus.q_full}, 8'h01);
      checkOutput("fifo_ovf", {7'd0, bus.overflow}, 8'h01);
      checkOutput("fifo_count", {5'd0, bus.q_count}, 8'h04);
      checkOutput("fifo_head", bus.scpu_dout, 8'h01);
      applyStimulus(1'b1, 8'h88, 1'b0, 1'b0, 1'b1);
      tick(1);
      checkOutput("ovf_set_wins", {7'd0, bus.overflow}, 8'h01);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick(1);
      checkOutput("ovf_clr", {7'd0, bus.overflow}, 8'h00);
      applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(8'h77);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("full_pushpop_count", {5'd0, bus.q_count}, 8'h04);
      checkOutput("full_pushpop_ovf", {7'd0, bus.overflow}, 8'h00);
      for (int i = 0; i < 4; i++) serviceOne("fifo_svc");
      tick(2);
      checkOutput("fifo_drained_int", {7'd0, bus.scpu_int}, 8'h00);
      checkOutput("fifo_drained_dout", bus.scpu_dout, 8'hFF);
      pushByte(8'hA1);
      pushByte(8'hA2);
      pushByte(8'hA3);
`else
      pushByte(8'hAA);
      pushByte(8'hBB);
      checkOutput("latch_dout", bus.scpu_dout, 8'hBB);
      checkOutput("latch_ovf", {7'd0, bus.overflow}, 8'h01);
      checkOutput("latch_count", {5'd0, bus.q_count}, 8'h01);
      applyStimulus(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("ovf_set_wins", {7'd0, bus.overflow}, 8'h01);
      checkOutput("latch_overwrite", bus.scpu_dout, 8'hCC);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("ovf_clr", {7'd0, bus.overflow}, 8'h00);
      exp_q.push_back(8'hCC);
      serviceOne("latch_svc");
      pushByte(8'h11);
      exp_q.push_back(8'h11);
      applyStimulus(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(8'h22);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("full_pushpop_count", {5'd0, bus.q_count}, 8'h01);
      checkOutput("full_pushpop_ovf", {7'd0, bus.overflow}, 8'h00);
      checkOutput("full_pushpop_dout", bus.scpu_dout, 8'h22);
      tick(1);
      popByte();
      checkOutput("latch_drained", {7'd0, bus.q_empty}, 8'h01);
      pushByte(8'hA1);
`endif

      // Asynchronous reset in the middle of a pending interrupt
      waitInt("pre_reset_int");
      #2;
      reset = 1'b1;
      exp_q.delete();
      #1;
      checkOutput("async_dout", bus.scpu_dout, 8'hFF);
      checkOutput("async_count", {5'd0, bus.q_count}, 8'h00);
      checkOutput("async_int", {7'd0, bus.scpu_int}, 8'h00);
      checkOutput("async_empty", {7'd0, bus.q_empty}, 8'h01);
      applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      tick(2);
      reset = 1'b0;
      tick(1);
      checkOutput("held_strobe_push", bus.scpu_dout, 8'h5A);
      checkOutput("held_strobe_count", {5'd0, bus.q_count}, 8'h01);
      tick(2);
      checkOutput("held_strobe_once", {7'd0, bus.overflow}, 8'h00);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(8'h5A);
      serviceOne("post_reset_svc");
      tick(1);
      checkOutput("final_empty", {7'd0, bus.q_empty}, 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
